// File: rtl/zerogame_round_ctrl.sv
// rtl/zerogame_round_ctrl.sv - round sequencer for the three-player zero game
// Optional guess timeout enabled by defining ZG_TIMEOUT_EN.
module zerogame_round_ctrl #(
    parameter int REVEAL_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] sel_in,
    input  logic       sel_valid,
    input  logic [1:0] p1,
    input  logic [1:0] p2,
    input  logic [1:0] p3,
    output logic [2:0] state,
    output logic [1:0] caller,
    output logic [2:0] guess,
    output logic [2:0] sum,
    output logic       hit,
    output logic [1:0] hands1,
    output logic [1:0] hands2,
    output logic [1:0] hands3,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] rounds,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_REVEAL = 3'd2,
        S_JUDGE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] caller_q, caller_d;
    logic [2:0] guess_q, guess_d;
    logic [2:0] sum_q, sum_d;
    logic [1:0] hands1_q, hands1_d;
    logic [1:0] hands2_q, hands2_d;
    logic [1:0] hands3_q, hands3_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] rounds_q, rounds_d;
    logic [3:0] rev_q, rev_d;

    logic       sel_ok;
    logic [2:0] sel_enc;
    logic       hit_w;
    logic       timeout_w;
    logic [1:0] caller_hands;
    logic [1:0] caller_next;
    logic [7:0] rounds_inc;
    logic [2:0] masked_sum;

    // Thumbs of a player count only for hands still in play.
    function automatic logic [2:0] contrib(input logic [1:0] h, input logic [1:0] p);
        logic [2:0] c;
        c = 3'd0;
        if (h == 2'd2)
            c = {2'b00, p[1]} + {2'b00, p[0]};
        else if (h == 2'd1)
            c = {2'b00, p[0]};
        return c;
    endfunction

`ifdef ZG_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    assign timeout_w = (state_q == S_WAIT) && !sel_ok &&
                       (tmo_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_w = 1'b0;
`endif

    assign sel_ok = sel_valid && !sel_in[7] && (sel_in != 8'd0) &&
                    ((sel_in & (sel_in - 8'd1)) == 8'd0);
    assign hit_w       = (state_q == S_JUDGE) && (guess_q == sum_q);
    assign caller_next = (caller_q == 2'd2) ? 2'd0 : caller_q + 2'd1;
    assign rounds_inc  = (rounds_q == 8'hFF) ? rounds_q : rounds_q + 8'd1;
    assign masked_sum  = contrib(hands1_q, p1) + contrib(hands2_q, p2) +
                         contrib(hands3_q, p3);

    always_comb begin
        sel_enc = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (sel_in[k])
                sel_enc = 3'(k);
        end
    end

    always_comb begin
        case (caller_q)
            2'd0:    caller_hands = hands1_q;
            2'd1:    caller_hands = hands2_q;
            default: caller_hands = hands3_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        caller_d = caller_q;
        guess_d  = guess_q;
        sum_d    = sum_q;
        hands1_d = hands1_q;
        hands2_d = hands2_q;
        hands3_d = hands3_q;
        winner_d = winner_q;
        rounds_d = rounds_q;
        rev_d    = rev_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WAIT;
                    caller_d = 2'd0;
                    hands1_d = 2'd2;
                    hands2_d = 2'd2;
                    hands3_d = 2'd2;
                    winner_d = 2'd0;
                    rounds_d = 8'd0;
                end
            end
            S_WAIT: begin
                if (sel_ok) begin
                    guess_d = sel_enc;
                    rev_d   = 4'(REVEAL_CYCLES - 1);
                    state_d = S_REVEAL;
                end else if (timeout_w) begin
                    caller_d = caller_next;
                    rounds_d = rounds_inc;
                end
            end
            S_REVEAL: begin
                if (rev_q == 4'd0) begin
                    sum_d   = masked_sum;
                    state_d = S_JUDGE;
                end else begin
                    rev_d = rev_q - 4'd1;
                end
            end
            S_JUDGE: begin
                rounds_d = rounds_inc;
                if (hit_w) begin
                    case (caller_q)
                        2'd0:    hands1_d = hands1_q - 2'd1;
                        2'd1:    hands2_d = hands2_q - 2'd1;
                        default: hands3_d = hands3_q - 2'd1;
                    endcase
                end
                if (hit_w && caller_hands == 2'd1) begin
                    winner_d = caller_q;
                    state_d  = S_DONE;
                end else begin
                    caller_d = caller_next;
                    state_d  = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            caller_q <= 2'd0;
            guess_q  <= 3'd0;
            sum_q    <= 3'd0;
            hands1_q <= 2'd2;
            hands2_q <= 2'd2;
            hands3_q <= 2'd2;
            winner_q <= 2'd0;
            rounds_q <= 8'd0;
            rev_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            caller_q <= caller_d;
            guess_q  <= guess_d;
            sum_q    <= sum_d;
            hands1_q <= hands1_d;
            hands2_q <= hands2_d;
            hands3_q <= hands3_d;
            winner_q <= winner_d;
            rounds_q <= rounds_d;
            rev_q    <= rev_d;
        end
    end

`ifdef ZG_TIMEOUT_EN
    // Counter restarts on every entry to WAIT_GUESS and after each forfeit.
    always_comb begin
        tmo_d = 8'd0;
        if (state_q == S_WAIT && state_d == S_WAIT && !timeout_w)
            tmo_d = tmo_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            tmo_q <= 8'd0;
        else
            tmo_q <= tmo_d;
    end
`endif

    assign state     = state_q;
    assign caller    = caller_q;
    assign guess     = guess_q;
    assign sum       = sum_q;
    assign hit       = hit_w;
    assign hands1    = hands1_q;
    assign hands2    = hands2_q;
    assign hands3    = hands3_q;
    assign game_over = (state_q == S_DONE);
    assign winner    = winner_q;
    assign rounds    = rounds_q;
    assign timeout   = timeout_w;

endmodule

// File: tb/tb_zerogame_round_ctrl.sv
// tb/tb_zerogame_round_ctrl.sv - directed self-checking bench for zerogame_round_ctrl
module tb_zerogame_round_ctrl;

    localparam int R = 4;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset, start, sel_valid;
    logic [7:0] sel_in;
    logic [1:0] p1, p2, p3;
    logic [2:0] state, guess, sum;
    logic [1:0] caller, hands1, hands2, hands3, winner;
    logic       hit, game_over, timeout;
    logic [7:0] rounds;

    int errors = 0;
    int checks = 0;

    zerogame_round_ctrl #(.REVEAL_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .start(start), .sel_in(sel_in), .sel_valid(sel_valid),
        .p1(p1), .p2(p2), .p3(p3), .state(state), .caller(caller), .guess(guess),
        .sum(sum), .hit(hit), .hands1(hands1), .hands2(hands2), .hands3(hands3),
        .game_over(game_over), .winner(winner), .rounds(rounds), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Commit a guess, drive decoy thumbs except in the last reveal cycle,
    // and return at the judge sample with the observed hit timing.
    task automatic play_round(input logic [7:0] sel, input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, output int lat, output logic hit_seen,
                              output logic [2:0] sum_seen, output logic [2:0] st_seen);
        lat = 0;
        hit_seen = 1'b0;
        sel_in = sel;
        sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        sel_in = 8'h00;
        for (int k = 1; k <= R + 1; k++) begin
            if (k == R) begin
                p1 = a; p2 = b; p3 = c;
            end else begin
                p1 = 2'b11; p2 = 2'b11; p3 = 2'b11;
            end
            if (hit && !hit_seen) begin
                hit_seen = 1'b1;
                lat = k;
            end
            if (k < R + 1)
                tick();
        end
        sum_seen = sum;
        st_seen = state;
        p1 = 2'b11; p2 = 2'b11; p3 = 2'b11;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sel_valid = 1'b0; sel_in = 8'h00;
        p1 = 2'b00; p2 = 2'b00; p3 = 2'b00;
        tick(); tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if ({hands1, hands2, hands3} !== 6'b101010) begin errors++; $display("FAIL reset_hands: got %0d/%0d/%0d expected 2/2/2", hands1, hands2, hands3); end
        checks++; if ({caller, guess, sum, hit, game_over, winner, rounds, timeout} !== 22'd0) begin errors++; $display("FAIL reset_outputs: got caller=%0d guess=%0d sum=%0d hit=%0d go=%0d win=%0d rounds=%0d to=%0d expected all 0", caller, guess, sum, hit, game_over, winner, rounds, timeout); end
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
    endtask

    task automatic test_first_round();
        int lat; logic hs; logic [2:0] sm, st;
        pulse_start();
        checks++; if (state !== 3'd1 || caller !== 2'd0) begin errors++; $display("FAIL start_wait: got state=%0d caller=%0d expected 1/0", state, caller); end
        play_round(8'h08, 2'b11, 2'b01, 2'b00, lat, hs, sm, st);
        checks++; if (lat !== R + 1) begin errors++; $display("FAIL hit_latency: got %0d expected %0d", lat, R + 1); end
        checks++; if (sm !== 3'd3 || guess !== 3'd3 || st !== 3'd3) begin errors++; $display("FAIL r1_sum_guess: got sum=%0d guess=%0d state=%0d expected 3/3/3", sm, guess, st); end
        tick();
        checks++; if (hit !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL r1_after: got hit=%0d state=%0d expected 0/1", hit, state); end
        checks++; if (hands1 !== 2'd1 || caller !== 2'd1 || rounds !== 8'd1) begin errors++; $display("FAIL r1_update: got hands1=%0d caller=%0d rounds=%0d expected 1/1/1", hands1, caller, rounds); end
    endtask

    task automatic test_masking();
        int lat; logic hs; logic [2:0] sm, st;
        play_round(8'h04, 2'b11, 2'b00, 2'b01, lat, hs, sm, st);
        checks++; if (sm !== 3'd2 || hs !== 1'b1) begin errors++; $display("FAIL mask_sum: got sum=%0d hit=%0d expected 2/1", sm, hs); end
        tick();
        checks++; if ({hands1, hands2, hands3} !== 6'b010110 || caller !== 2'd2) begin errors++; $display("FAIL mask_update: got hands=%0d/%0d/%0d caller=%0d expected 1/1/2 caller 2", hands1, hands2, hands3, caller); end
    endtask

    task automatic test_miss();
        int lat; logic hs; logic [2:0] sm, st;
        play_round(8'h40, 2'b00, 2'b00, 2'b10, lat, hs, sm, st);
        checks++; if (hs !== 1'b0 || sm !== 3'd1 || guess !== 3'd6) begin errors++; $display("FAIL miss_judge: got hit=%0d sum=%0d guess=%0d expected 0/1/6", hs, sm, guess); end
        tick();
        checks++; if ({hands1, hands2, hands3} !== 6'b010110 || caller !== 2'd0 || rounds !== 8'd3) begin errors++; $display("FAIL miss_update: got hands=%0d/%0d/%0d caller=%0d rounds=%0d expected 1/1/2 0 3", hands1, hands2, hands3, caller, rounds); end
    endtask

    task automatic test_illegal();
        logic [7:0] bad [3] = '{8'h0C, 8'h00, 8'h80};
        for (int i = 0; i < 3; i++) begin
            sel_in = bad[i];
            sel_valid = 1'b1;
            tick();
            checks++; if (state !== 3'd1 || guess !== 3'd6) begin errors++; $display("FAIL illegal_%0h: got state=%0d guess=%0d expected 1/6", bad[i], state, guess); end
        end
        sel_valid = 1'b0;
    endtask

    task automatic test_win();
        int lat; logic hs; logic [2:0] sm, st;
        play_round(8'h01, 2'b00, 2'b00, 2'b00, lat, hs, sm, st);
        checks++; if (hs !== 1'b1 || guess !== 3'd0 || sm !== 3'd0) begin errors++; $display("FAIL win_judge: got hit=%0d guess=%0d sum=%0d expected 1/0/0", hs, guess, sm); end
        tick();
        checks++; if (state !== 3'd4 || game_over !== 1'b1 || winner !== 2'd0 || hands1 !== 2'd0 || rounds !== 8'd4) begin errors++; $display("FAIL win_done: got state=%0d go=%0d win=%0d hands1=%0d rounds=%0d expected 4/1/0/0/4", state, game_over, winner, hands1, rounds); end
        sel_in = 8'h02; sel_valid = 1'b1;
        tick(); tick();
        sel_valid = 1'b0; sel_in = 8'h00;
        checks++; if (state !== 3'd4 || guess !== 3'd0 || game_over !== 1'b1) begin errors++; $display("FAIL done_hold: got state=%0d guess=%0d go=%0d expected 4/0/1", state, guess, game_over); end
    endtask

    task automatic test_restart();
        pulse_start();
        checks++; if (state !== 3'd1 || caller !== 2'd0 || game_over !== 1'b0 || rounds !== 8'd0) begin errors++; $display("FAIL restart_state: got state=%0d caller=%0d go=%0d rounds=%0d expected 1/0/0/0", state, caller, game_over, rounds); end
        checks++; if ({hands1, hands2, hands3} !== 6'b101010) begin errors++; $display("FAIL restart_hands: got %0d/%0d/%0d expected 2/2/2", hands1, hands2, hands3); end
    endtask

    task automatic test_reset_mid_reveal();
        int lat; logic hs; logic [2:0] sm, st;
        play_round(8'h01, 2'b00, 2'b00, 2'b00, lat, hs, sm, st);
        tick();
        checks++; if (hands1 !== 2'd1 || rounds !== 8'd1 || caller !== 2'd1) begin errors++; $display("FAIL pre_reset_round: got hands1=%0d rounds=%0d caller=%0d expected 1/1/1", hands1, rounds, caller); end
        sel_in = 8'h02; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0; sel_in = 8'h00;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL mid_reveal: got state=%0d expected 2", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0 || {hands1, hands2, hands3} !== 6'b101010 || hit !== 1'b0 || rounds !== 8'd0 || caller !== 2'd0) begin errors++; $display("FAIL reset_mid: got state=%0d hands=%0d/%0d/%0d hit=%0d rounds=%0d caller=%0d expected 0 2/2/2 0 0 0", state, hands1, hands2, hands3, hit, rounds, caller); end
    endtask

    task automatic test_reset_vs_start();
        reset = 1'b1; start = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_wins: got state=%0d expected 0", state); end
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_after: got state=%0d expected 0", state); end
    endtask

    task automatic test_timeout();
        pulse_start();
`ifdef ZG_TIMEOUT_EN
        for (int k = 1; k <= T; k++) begin
            checks++; if (timeout !== (k == T)) begin errors++; $display("FAIL timeout_cycle%0d: got %0d expected %0d", k, timeout, (k == T)); end
            tick();
        end
        checks++; if (state !== 3'd1 || caller !== 2'd1 || rounds !== 8'd1 || {hands1, hands2, hands3} !== 6'b101010) begin errors++; $display("FAIL timeout_update: got state=%0d caller=%0d rounds=%0d hands=%0d/%0d/%0d expected 1/1/1 2/2/2", state, caller, rounds, hands1, hands2, hands3); end
`else
        for (int k = 1; k <= T + 2; k++) begin
            checks++; if (timeout !== 1'b0 || state !== 3'd1 || caller !== 2'd0) begin errors++; $display("FAIL no_timeout_cycle%0d: got to=%0d state=%0d caller=%0d expected 0/1/0", k, timeout, state, caller); end
            tick();
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_round();
        test_masking();
        test_miss();
        test_illegal();
        test_win();
        test_restart();
        test_reset_mid_reveal();
        test_reset_vs_start();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zerogame_round_ctrl.md
Name: zerogame_round_ctrl

Overview:
- Round sequencer for the three-player zero game.
- Owns turn order, the guess/reveal/judge timing and each player's remaining-hand count.
- Drives the latched guess and thumb sum that feed the compare and 7-segment datapath.
- Replaces free-running per-clock latching of selector and player inputs with a controlled round protocol.

Parameters:
- REVEAL_CYCLES, 4, cycles the reveal window stays open before thumbs are sampled (legal range 1..15).
- TIMEOUT_CYCLES, 64, cycles the caller has to commit a guess; used only when ZG_TIMEOUT_EN is defined (legal range 1..255).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new game from IDLE or DONE.
- sel_in  input  8  one-hot guess from the current caller; bit k means guess k, k=0..6; bit 7 is illegal.
- sel_valid  input  1  caller commits sel_in this cycle.
- p1  input  2  player 1 thumbs up, one bit per hand.
- p2  input  2  player 2 thumbs up.
- p3  input  2  player 3 thumbs up.
- state  output  3  IDLE=0, WAIT_GUESS=1, REVEAL=2, JUDGE=3, DONE=4.
- caller  output  2  current caller: 0=p1, 1=p2, 2=p3.
- guess  output  3  latched guess value.
- sum  output  3  latched, masked thumb total, 0..6.
- hit  output  1  one-cycle pulse when guess equals sum.
- hands1, hands2, hands3  output  2 each  remaining hands per player, 0..2.
- game_over  output  1  high while in DONE.
- winner  output  2  winning player index; valid while game_over=1.
- rounds  output  8  completed rounds; saturates at 255.
- timeout  output  1  forfeit pulse; tied to 0 when ZG_TIMEOUT_EN is undefined.

Behaviour:
- Reset (synchronous, highest priority, any state including mid-round):
  - state=IDLE, caller=0, guess=0, sum=0, hit=0, hands1..3=2, game_over=0, winner=0, rounds=0, timeout=0; internal counters cleared.
- IDLE:
  - start=1 -> WAIT_GUESS. Re-initialise hands to 2, caller=0, rounds=0.
- WAIT_GUESS:
  - Accept when sel_valid=1 and sel_in is exactly one-hot with bit 7 clear.
  - On accept: guess <= encoded value, next state REVEAL, reveal counter loaded with REVEAL_CYCLES-1.
  - Illegal sel_in (zero, multi-hot, or bit 7 set) with sel_valid=1: ignored, stay in WAIT_GUESS, no output changes.
- REVEAL:
  - Counter decrements each cycle; the state lasts exactly REVEAL_CYCLES cycles.
  - On the last cycle (counter==0), sum <= masked popcount, then next state JUDGE.
  - Masking: a player with hands=2 contributes p[1]+p[0]; hands=1 contributes p[0] only; hands=0 contributes 0.
  - Inputs p1..p3 are ignored on all other cycles.
- JUDGE (one cycle):
  - hit=1 for this cycle iff guess==sum; otherwise hit=0.
  - On hit: the caller's hands count decrements by 1.
  - rounds increments (saturating at 255).
  - If the caller's hands reach 0 -> DONE, winner=caller, game_over=1.
  - Otherwise caller <= (caller+1) mod 3 and next state WAIT_GUESS.
  - Every non-winning player always has hands>0, so rotation never skips a player.
- DONE:
  - Holds all outputs. start=1 -> behaves as IDLE+start: re-init, WAIT_GUESS. start in any other state is ignored.
- Latency: from the guess-accept edge to the hit pulse is REVEAL_CYCLES+1 cycles; from the hit pulse to the next WAIT_GUESS is 1 cycle.
- guess and sum hold their values until overwritten, so the display datapath reads stable values.
- Simultaneous reset and start: reset wins.
- sel_valid outside WAIT_GUESS is ignored.

Optional Feature:
- Macro ZG_TIMEOUT_EN.
- Defined:
  - WAIT_GUESS runs an 8-bit counter from 0, cleared on entry.
  - If it reaches TIMEOUT_CYCLES-1 with no accepted guess: timeout pulses for 1 cycle, caller advances mod 3, rounds increments, no hands change, state stays WAIT_GUESS, counter clears.
  - An accepted guess on the expiry cycle takes priority over the timeout.
- Undefined: no timeout counter; timeout is constantly 0; WAIT_GUESS waits indefinitely.

Test Plan:
- Reset then start; caller 0 sends sel_in=8'h08 with p1=11, p2=01, p3=00 in the last REVEAL cycle -> sum=3, guess=3, hit=1 exactly REVEAL_CYCLES+1 cycles after accept, hands1=1, caller=1, rounds=1.
- Masking: with hands1=1, caller 1 sends 8'h04 with p1=11, p2=00, p3=01 -> sum=2 (p1[1] masked), hit=1, hands2=1, caller=2.
- Miss path: caller 2 sends 8'h40 while total thumbs=1 -> hit=0, all hands unchanged, caller wraps to 0.
- Illegal guesses: sel_in=8'h0C, 8'h00, 8'h80 with sel_valid=1 -> state stays 1, guess unchanged; a following 8'h01 is accepted.
- Win: drive caller 0 to a second hit -> state=4, game_over=1, winner=0; sel_valid ignored; start -> hands all 2, caller=0, state=1.
- Reset asserted mid-REVEAL -> next cycle state=0, hands=2/2/2, hit=0, rounds=0.
- With ZG_TIMEOUT_EN and TIMEOUT_CYCLES=8: no guess for 8 cycles -> timeout pulse, caller 0->1, rounds+1, hands unchanged.
